// File: rtl/cdf_controller.sv
// Sequencing FSM for cdf_datapath: steps NUM_PAIRS histogram word pairs through read, wait, compute and write.
// Outputs are registered from next-state, so each strobe lines up with the state it belongs to.
module cdf_controller #(
    parameter int NUM_PAIRS       = 32,
    parameter int MEM_LAT         = 1,
    parameter int WRITES_PER_PAIR = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    output logic                         read_first_value,
    output logic                         read_next_value,
    output logic                         scratch_mem_read_ready,
    output logic                         cdf_computation_done,
    output logic                         cdf_done,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_PAIRS)-1:0] pair_idx
);
    localparam int PW      = $clog2(NUM_PAIRS);
    localparam int CNT_MAX = (MEM_LAT > WRITES_PER_PAIR - 1) ? MEM_LAT : WRITES_PER_PAIR - 1;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [PW-1:0] LAST_PAIR = PW'(NUM_PAIRS - 1);

    typedef enum logic [2:0] {
        IDLE, FIRST, WAIT, COMPUTE, WRITE, NEXT, FINAL, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pair_q, pair_d;
    logic           rfv_q, rfv_d, rnv_q, rnv_d, rdy_q, rdy_d;
    logic           cdone_q, cdone_d, cdfd_q, cdfd_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = FIRST;
            FIRST:   begin state_d = WAIT; cnt_d = CW'(MEM_LAT); end
            WAIT:    if (cnt_q == '0) state_d = COMPUTE;
                     else cnt_d = cnt_q - CW'(1);
            COMPUTE: begin state_d = WRITE; cnt_d = CW'(WRITES_PER_PAIR - 1); end
            WRITE:   if (cnt_q == '0) state_d = (pair_q == LAST_PAIR) ? FINAL : NEXT;
                     else cnt_d = cnt_q - CW'(1);
            NEXT:    begin state_d = WAIT; cnt_d = CW'(MEM_LAT); end
            FINAL:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) state_d = IDLE;

        // Counters reload on entry, so nothing carries over between runs or after abort.
        if (state_d == IDLE || state_d == FIRST) begin
            pair_d = '0;
            cnt_d  = '0;
        end else if (state_d == NEXT && state_q == WRITE) begin
            pair_d = pair_q + PW'(1);
        end

        rfv_d   = (state_d == FIRST);
        rnv_d   = (state_d == NEXT);
        rdy_d   = (state_d == COMPUTE);
        cdone_d = (state_d == WRITE);
        cdfd_d  = (state_d == FINAL);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pair_q  <= '0;
            rfv_q   <= 1'b0;
            rnv_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cdone_q <= 1'b0;
            cdfd_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            rfv_q   <= rfv_d;
            rnv_q   <= rnv_d;
            rdy_q   <= rdy_d;
            cdone_q <= cdone_d;
            cdfd_q  <= cdfd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign read_first_value       = rfv_q;
    assign read_next_value        = rnv_q;
    assign scratch_mem_read_ready = rdy_q;
    assign cdf_computation_done   = cdone_q;
    assign cdf_done               = cdfd_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign pair_idx               = pair_q;
endmodule

// File: tb/tb_cdf_controller.sv
// Directed bench for cdf_controller: timeline vector table plus multi-cycle corner sequences.
// A second instance covers a small non-default parameter set.
module tb_cdf_controller;
    logic clk = 1'b0;
    logic reset, start, abort, start6;
    logic rfv, rnv, rdy, cdone, cdfd, busy, done;
    logic [4:0] pidx;
    logic rfv6, rnv6, rdy6, cdone6, cdfd6, busy6, done6;
    logic [1:0] pidx6;

    always #5 clk = ~clk;

    cdf_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .read_first_value(rfv), .read_next_value(rnv), .scratch_mem_read_ready(rdy),
        .cdf_computation_done(cdone), .cdf_done(cdfd), .busy(busy), .done(done),
        .pair_idx(pidx)
    );

    cdf_controller #(.NUM_PAIRS(4), .MEM_LAT(3), .WRITES_PER_PAIR(1)) u6 (
        .clk(clk), .reset(reset), .start(start6), .abort(1'b0),
        .read_first_value(rfv6), .read_next_value(rnv6), .scratch_mem_read_ready(rdy6),
        .cdf_computation_done(cdone6), .cdf_done(cdfd6), .busy(busy6), .done(done6),
        .pair_idx(pidx6)
    );

    // Order: read_first, read_next, read_ready, computation_done, cdf_done, busy, done
    wire [6:0] obs = {rfv, rnv, rdy, cdone, cdfd, busy, done};

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    typedef struct {
        int         cyc;
        logic       start;
        logic [6:0] exp;
        logic [4:0] pidx;
    } vec_t;
    vec_t vt[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle 1 is the cycle after the edge that samples start.
    task automatic begin_run();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_f, cnt_n, cnt_r, cnt_c, cnt_cd, cnt_d, overlap, lowbusy, seen;

        vt[0]  = '{1,   1'b0, 7'b1000010, 5'd0};
        vt[1]  = '{2,   1'b0, 7'b0000010, 5'd0};
        vt[2]  = '{4,   1'b0, 7'b0010010, 5'd0};
        vt[3]  = '{5,   1'b0, 7'b0001010, 5'd0};
        vt[4]  = '{6,   1'b0, 7'b0001010, 5'd0};
        vt[5]  = '{7,   1'b0, 7'b0100010, 5'd1};
        vt[6]  = '{8,   1'b0, 7'b0000010, 5'd1};
        vt[7]  = '{10,  1'b0, 7'b0010010, 5'd1};
        vt[8]  = '{191, 1'b0, 7'b0001010, 5'd31};
        vt[9]  = '{193, 1'b0, 7'b0000110, 5'd31};
        vt[10] = '{194, 1'b1, 7'b0000011, 5'd31};
        vt[11] = '{195, 1'b0, 7'b0000000, 5'd0};
        vt[12] = '{196, 1'b0, 7'b0000000, 5'd0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; start6 = 1'b0;
        #12;
        check("reset_outputs", {4'd0, obs, pidx}, 16'd0);
        check("reset_outputs_p6", {7'd0, rfv6, rnv6, rdy6, cdone6, cdfd6, busy6, done6, pidx6}, 16'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Default-parameter timeline; start raised on the done cycle must be ignored.
        begin_run();
        for (int i = 0; i < 13; i++) begin
            while (cyc < vt[i].cyc) tick();
            check($sformatf("timeline_c%0d", vt[i].cyc), {4'd0, obs, pidx}, {4'd0, vt[i].exp, vt[i].pidx});
            start = vt[i].start;
        end

        // Strobe census over a full run.
        cnt_f = 0; cnt_n = 0; cnt_r = 0; cnt_c = 0; cnt_cd = 0; cnt_d = 0; overlap = 0;
        begin_run();
        for (int k = 0; k < 400; k++) begin
            cnt_f += int'(rfv); cnt_n += int'(rnv); cnt_r += int'(rdy);
            cnt_c += int'(cdone); cnt_cd += int'(cdfd); cnt_d += int'(done);
            if (int'(rfv) + int'(rnv) + int'(rdy) + int'(cdone) + int'(cdfd) > 1) overlap++;
            if (done) break;
            tick();
        end
        tick();
        check("count_first", 16'(cnt_f), 16'd1);
        check("count_next", 16'(cnt_n), 16'd31);
        check("count_ready", 16'(cnt_r), 16'd32);
        check("count_comp_done", 16'(cnt_c), 16'd64);
        check("count_cdf_done", 16'(cnt_cd), 16'd1);
        check("count_done", 16'(cnt_d), 16'd1);
        check("strobe_overlap", 16'(overlap), 16'd0);

        // start held high for the whole run.
        lowbusy = 0; seen = 0;
        start = 1'b1; cyc = 0; tick();
        for (int k = 0; k < 400 && seen == 0; k++) begin
            if (!busy) lowbusy++;
            if (done) seen = 1;
            else tick();
        end
        check("held_done_cycle", 16'(cyc), 16'd194);
        check("held_busy_low", 16'(lowbusy), 16'd0);
        tick();
        check("held_idle_gap", {9'd0, obs}, 16'd0);
        tick();
        check("held_restart", {9'd0, obs}, {9'd0, 7'b1000010});
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held_abort_clean", {4'd0, obs, pidx}, 16'd0);

        // abort during pair 10 WRITE.
        begin_run();
        while (cyc < 65) tick();
        check("pair10_write", {4'd0, obs, pidx}, {4'd0, 7'b0001010, 5'd10});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_next_cycle", {4'd0, obs, pidx}, 16'd0);
        cnt_d = 0;
        for (int k = 0; k < 5; k++) begin tick(); cnt_d += int'(done) + int'(busy); end
        check("abort_no_done", 16'(cnt_d), 16'd0);
        seen = 0;
        begin_run();
        for (int k = 0; k < 400 && seen == 0; k++) begin
            if (done) seen = 1;
            else tick();
        end
        check("post_abort_run", 16'(cyc), 16'd194);
        tick();

        // abort and start together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", {9'd0, obs}, 16'd0);

        // Asynchronous reset in WAIT, between clock edges.
        begin_run();
        tick();
        check("wait_state", {4'd0, obs, pidx}, {4'd0, 7'b0000010, 5'd0});
        #2 reset = 1'b1;
        #1;
        check("async_reset", {4'd0, obs, pidx}, 16'd0);
        #1 reset = 1'b0;
        lowbusy = 0;
        for (int k = 0; k < 4; k++) begin tick(); lowbusy += int'(busy) + int'(rfv); end
        check("idle_after_reset", 16'(lowbusy), 16'd0);

        // Small instance: edges from the start-sampling edge to done high.
        cnt_c = 0; seen = 0;
        start6 = 1'b1; cyc = 0; tick(); start6 = 1'b0;
        for (int k = 0; k < 100 && seen == 0; k++) begin
            cnt_c += int'(cdone6);
            if (done6) seen = 1;
            else tick();
        end
        check("p6_done_latency", 16'(cyc - 1), 16'd29);
        check("p6_comp_done_cycles", 16'(cnt_c), 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
